// File: rtl/axi_lite_mem_slave_if.sv
// AXI-Lite bus bundle between a master (core im/dm port or bench) and the word-RAM subordinate.
// Write channels AW/W/B and read channels AR/R; prot fields are carried but carry no meaning here.
interface axi_lite_mem_slave_if #(
  parameter int ALEN = 64,
  parameter int DLEN = 64
);
  localparam int STRB = DLEN / 8;

  logic            awvalid;
  logic            awready;
  logic [ALEN-1:0] awaddr;
  logic [2:0]      awprot;
  logic            wvalid;
  logic            wready;
  logic [DLEN-1:0] wdata;
  logic [STRB-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [ALEN-1:0] araddr;
  logic [2:0]      arprot;
  logic            rvalid;
  logic            rready;
  logic [DLEN-1:0] rdata;
  logic [1:0]      rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite word-RAM subordinate: independent read/write engines, one outstanding each, 1-cycle response
// after the last address/data handshake; responses held until accepted, readies low while a response waits.
module axi_lite_mem_slave #(
  parameter int              ALEN      = 64,
  parameter int              DLEN      = 64,
  parameter int              DEPTH     = 1024,
  parameter logic [ALEN-1:0] BASE_ADDR = '0
) (
  input logic                 clk,
  input logic                 rstn,
  axi_lite_mem_slave_if.slave bus
);
  localparam int STRB = DLEN / 8;
  localparam int OFFW = $clog2(STRB);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ALEN-1:0] SPAN = ALEN'(DEPTH * STRB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DLEN-1:0] mem [DEPTH];

  logic [0:0]      w_state_q, w_state_d;
  logic            awready_q, awready_d, wready_q, wready_d;
  logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ALEN-1:0] awaddr_q, awaddr_d;
  logic [DLEN-1:0] wdata_q, wdata_d;
  logic [STRB-1:0] wstrb_q, wstrb_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;

  logic [0:0]      r_state_q, r_state_d;
  logic            arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;

  logic            aw_hs, w_hs, ar_hs, w_in_range, r_in_range, mem_we;
  logic [ALEN-1:0] waddr_sel, w_off, r_off;
  logic [DLEN-1:0] wdata_sel;
  logic [STRB-1:0] wstrb_sel;
  logic [IDXW-1:0] mem_widx, mem_ridx;

  // Offsets below BASE_ADDR wrap to huge values, so one unsigned compare covers both bounds.
  assign aw_hs      = bus.awvalid & awready_q;
  assign w_hs       = bus.wvalid & wready_q;
  assign ar_hs      = bus.arvalid & arready_q;
  assign waddr_sel  = aw_held_q ? awaddr_q : bus.awaddr;
  assign wdata_sel  = w_held_q ? wdata_q : bus.wdata;
  assign wstrb_sel  = w_held_q ? wstrb_q : bus.wstrb;
  assign w_off      = waddr_sel - BASE_ADDR;
  assign r_off      = bus.araddr - BASE_ADDR;
  assign w_in_range = w_off < SPAN;
  assign r_in_range = r_off < SPAN;
  assign mem_widx   = w_off[OFFW +: IDXW];
  assign mem_ridx   = r_off[OFFW +: IDXW];

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = bus.awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = bus.wdata;
          wstrb_d  = bus.wstrb;
        end
        if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
          mem_we    = w_in_range;
          bvalid_d  = 1'b1;
          bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          awready_d = ~(aw_held_q | aw_hs);
          wready_d  = ~(w_held_q | w_hs);
        end
      end
      default: begin
        if (bus.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
    endcase
  end

  // Combinational RAM read sees the pre-edge contents, so a same-edge write is not visible.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = r_in_range ? mem[mem_ridx] : '0;
          rresp_d   = r_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      default: begin
        if (bus.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB; b++) begin
        if (wstrb_sel[b]) mem[mem_widx][8*b +: 8] <= wdata_sel[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  logic unused_sigs;
  assign unused_sigs = ^{bus.awprot, bus.arprot, w_off, r_off};
endmodule
